// File: rtl/muldiv_unit.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// Define MULDIV_MADD_EN to implement MADD/MADDU/MSUB/MSUBU (ops 6-9).
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0]  DIV_LAST = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   opa_q;     // |a|, doubles as the quotient shift register
  logic [WIDTH-1:0]   opb_q;     // |b|
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   a_q;       // raw dividend, returned in hi on divide by zero
  logic               neg_q;
  logic               sign_a_q;
  logic               zero_q;
`ifdef MULDIV_MADD_EN
  logic               acc_q;
  logic               sub_q;
  logic               op_acc;
  logic               op_sub;
`endif

  logic               op_mul, op_div, op_signed, op_mthi, op_mtlo;
  logic               sign_a_in, sign_b_in;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;
  logic [CW-1:0]      mul_first;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    op_mul    = 1'b0;
    op_div    = 1'b0;
    op_signed = 1'b0;
    op_mthi   = 1'b0;
    op_mtlo   = 1'b0;
`ifdef MULDIV_MADD_EN
    op_acc    = 1'b0;
    op_sub    = 1'b0;
`endif
    case (op)
      OP_MULT:  begin op_mul = 1'b1; op_signed = 1'b1; end
      OP_MULTU: op_mul = 1'b1;
      OP_DIV:   begin op_div = 1'b1; op_signed = 1'b1; end
      OP_DIVU:  op_div = 1'b1;
      OP_MTHI:  op_mthi = 1'b1;
      OP_MTLO:  op_mtlo = 1'b1;
`ifdef MULDIV_MADD_EN
      OP_MADD:  begin op_mul = 1'b1; op_acc = 1'b1; op_signed = 1'b1; end
      OP_MADDU: begin op_mul = 1'b1; op_acc = 1'b1; end
      OP_MSUB:  begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; op_signed = 1'b1; end
      OP_MSUBU: begin op_mul = 1'b1; op_acc = 1'b1; op_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign sign_a_in = op_signed & a[WIDTH-1];
  assign sign_b_in = op_signed & b[WIDTH-1];
  assign mag_a_in  = sign_a_in ? -a : a;
  assign mag_b_in  = sign_b_in ? -b : b;

`ifdef MULDIV_MADD_EN
  assign mul_first = op_acc ? CW'(MUL_LAT) : MUL_LAST;
`else
  assign mul_first = MUL_LAST;
`endif

  // Multiply datapath: magnitude product, sign applied afterwards.
  logic [2*WIDTH-1:0] prod_mag, prod_signed, mul_res;
  assign prod_mag    = {{WIDTH{1'b0}}, opa_q} * {{WIDTH{1'b0}}, opb_q};
  assign prod_signed = neg_q ? -prod_mag : prod_mag;

  always_comb begin
    mul_res = prod_signed;
`ifdef MULDIV_MADD_EN
    if (acc_q)
      mul_res = sub_q ? ({hi, lo} - prod_signed) : ({hi, lo} + prod_signed);
`endif
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_bit;
  logic [WIDTH-1:0] div_rem_nxt;
  assign div_shift   = {rem_q, opa_q[WIDTH-1]};
  assign div_bit     = (div_shift >= {1'b0, opb_q});
  assign div_diff    = div_shift - {1'b0, opb_q};
  assign div_rem_nxt = div_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

  assign busy = (state != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      rem_q    <= '0;
      a_q      <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_q    <= 1'b0;
      sub_q    <= 1'b0;
`endif
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dbz      <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          if (op_mthi) hi <= a;
          if (op_mtlo) lo <= a;
          if (op_mul || op_div) begin
            opa_q    <= mag_a_in;
            opb_q    <= mag_b_in;
            a_q      <= a;
            rem_q    <= '0;
            neg_q    <= sign_a_in ^ sign_b_in;
            sign_a_q <= sign_a_in;
            zero_q   <= (b == '0);
`ifdef MULDIV_MADD_EN
            acc_q    <= op_acc;
            sub_q    <= op_sub;
`endif
            state    <= op_mul ? S_MUL : S_DIV;
            cnt      <= op_mul ? mul_first : DIV_LAST;
          end
        end
        S_MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= mul_res;
            done     <= 1'b1;
            state    <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DIV: begin
          rem_q <= div_rem_nxt;
          opa_q <= {opa_q[WIDTH-2:0], div_bit};
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - CW'(1);
        end
        S_FIX: begin
          if (zero_q) begin
            lo <= '1;
            hi <= a_q;
          end else begin
            lo <= neg_q    ? -opa_q : opa_q;
            hi <= sign_a_q ? -rem_q : rem_q;
          end
          dbz   <= zero_q;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32, MUL_LAT=2): directed plan cases plus
// randomized ops against an arithmetic reference model of HI/LO.
module tb_muldiv_unit;

  localparam int W   = 32;
  localparam int LAT = 2;
`ifdef MULDIV_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done, dbz;
  logic [W-1:0]  hi, lo;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(W), .MUL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: architectural result of one op from the ISA rules, plus its latency (0 = no busy).
  task automatic model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] eh, output logic [W-1:0] el,
                       output logic ed, output int lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    eh = hi_m; el = lo_m; ed = 1'b0; lat = 0; p = '0;
    sa = longint'($signed(x));
    sb = longint'($signed(y));
    case (o)
      4'd0: begin p = sa * sb; {eh, el} = p; lat = LAT; end
      4'd1: begin p = {32'b0, x} * {32'b0, y}; {eh, el} = p; lat = LAT; end
      4'd2, 4'd3: begin
        lat = W + 1;
        if (y == 0) begin
          el = '1; eh = x; ed = 1'b1;
        end else if (o == 4'd2) begin
          q = sa / sb; r = sa % sb;
          el = q[31:0]; eh = r[31:0];
        end else begin
          el = x / y; eh = x % y;
        end
      end
      4'd4: eh = x;
      4'd5: el = x;
      4'd6, 4'd7, 4'd8, 4'd9: if (MADD_EN) begin
        p = (o == 4'd6 || o == 4'd8) ? 64'(sa * sb) : ({32'b0, x} * {32'b0, y});
        {eh, el} = (o >= 4'd8) ? ({hi_m, lo_m} - p) : ({hi_m, lo_m} + p);
        lat = LAT + 1;
      end
      default: ;
    endcase
  endtask

  // Issue one op at a negedge, scramble inputs after acceptance, then wait (bounded) for done.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input string tag);
    logic [W-1:0] eh, el;
    logic ed;
    int lat, k;
    bit busy_ok;
    model(o, x, y, eh, el, ed, lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 4'($urandom_range(0, 15));
    if (lat == 0) begin
      check({tag, ".busy"}, busy, 0);
      check({tag, ".done"}, done, 0);
    end else begin
      busy_ok = 1'b1; k = 0;
      while (!done && k < 100) begin
        busy_ok &= (busy === 1'b1);
        @(posedge clk); #1;
        k++;
      end
      check({tag, ".lat"}, k, lat);
      check({tag, ".busy_hold"}, busy_ok, 1);
      check({tag, ".busy_end"}, busy, 0);
      check({tag, ".dbz"}, dbz, ed);
    end
    check({tag, ".hi"}, hi, eh);
    check({tag, ".lo"}, lo, el);
    hi_m = eh; lo_m = el;
  endtask

  initial begin
    bit quiet;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.dbz",  dbz,  0);
    check("rst.hi",   hi,   0);
    check("rst.lo",   lo,   0);
    @(negedge clk); rst = 1'b0;

    run_op(4'd0, 32'hFFFFFFFE, 32'd3, "mult");
    check("mult.hi_const", hi, 32'hFFFFFFFF);
    check("mult.lo_const", lo, 32'hFFFFFFFA);

    run_op(4'd2, 32'hFFFFFFF9, 32'd2, "div");
    check("div.lo_const", lo, 32'hFFFFFFFD);
    check("div.hi_const", hi, 32'hFFFFFFFF);
    run_op(4'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    check("div_ovf.lo_const", lo, 32'h80000000);
    check("div_ovf.hi_const", hi, 32'h0);

    run_op(4'd3, 32'h80000000, 32'h0, "divu_dbz");
    check("divu_dbz.dbz_const", dbz, 1);
    @(posedge clk); #1;
    check("divu_dbz.dbz_after", dbz, 0);
    check("divu_dbz.done_after", done, 0);

    run_op(4'd0, 32'h1234, 32'h5678, "pre_rst");
    // Abort a divide with reset while MULT starts are pulsed into the busy unit.
    @(negedge clk);
    op = 4'd2; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    quiet = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(negedge clk);
      start = e[0]; op = 4'd0; a = 32'd5; b = 32'd6;
      @(posedge clk); #1;
      quiet &= (done === 1'b0) && (busy === 1'b1);
    end
    check("abort.busy_no_done", quiet, 1);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    #1;
    check("abort.busy", busy, 0);
    check("abort.hi", hi, 0);
    check("abort.lo", lo, 0);
    check("abort.done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    for (int e = 0; e < 40; e++) begin
      @(posedge clk); #1;
      quiet &= (done === 1'b0) && (busy === 1'b0);
    end
    check("abort.quiet_after", quiet, 1);
    hi_m = '0; lo_m = '0;

    run_op(4'd4, 32'h0, 32'h0, "mthi");
    run_op(4'd5, 32'hFFFFFFFF, 32'h0, "mtlo");
    run_op(4'd7, 32'd1, 32'd1, "maddu");
    if (MADD_EN) begin
      check("maddu.hi_const", hi, 32'd1);
      check("maddu.lo_const", lo, 32'd0);
    end else begin
      check("maddu_off.hi_const", hi, 32'd0);
      check("maddu_off.lo_const", lo, 32'hFFFFFFFF);
    end

    run_op(4'd12, 32'hDEAD, 32'hBEEF, "reserved");

    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_a");
    run_op(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_b2b");
    check("multu_b2b.hi_const", hi, 32'hFFFFFFFE);
    check("multu_b2b.lo_const", lo, 32'h00000001);

    for (int i = 0; i < 30; i++) begin
      logic [3:0]   ro;
      logic [W-1:0] rx, ry;
      ro = 4'($urandom_range(0, 15));
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = '0;
        1: begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
        2: ry = 32'($urandom_range(1, 15));
        3: ry = -32'($urandom_range(1, 15));
        default: ;
      endcase
      run_op(ro, rx, ry, $sformatf("rand%0d_op%0d", i, ro));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
